// File: rtl/caxi4interconnect_sync_fifo_ctrl_if.sv
// rtl/caxi4interconnect_sync_fifo_ctrl_if.sv - push/pop and RAM-port bundle for the sync FIFO controller
//
// Purpose: groups the push side (wrValid/wrReady/wrData), the pop side
// (rdValid/rdReady/rdData), the occupancy count and the dual-port RAM
// signals (fifoWrAddr/fifoWrite/fifoWrData, fifoRdAddr/fifoRdData).
// Modports:
//   master - the FIFO controller: takes push requests, pop acks and RAM read
//            data; drives handshakes, head data, count and RAM controls.
//   slave  - the surrounding logic (producer, consumer and RAM).
interface caxi4interconnect_sync_fifo_ctrl_if #(
  parameter int FIFO_AWIDTH = 9,
  parameter int FIFO_WIDTH  = 8
);
  logic                   wrValid;
  logic                   wrReady;
  logic [FIFO_WIDTH-1:0]  wrData;
  logic                   rdValid;
  logic                   rdReady;
  logic [FIFO_WIDTH-1:0]  rdData;
  logic [FIFO_AWIDTH:0]   fifoCount;
  logic [FIFO_AWIDTH-1:0] fifoWrAddr;
  logic                   fifoWrite;
  logic [FIFO_WIDTH-1:0]  fifoWrData;
  logic [FIFO_AWIDTH-1:0] fifoRdAddr;
  logic [FIFO_WIDTH-1:0]  fifoRdData;

  modport master (
    input  wrValid, wrData, rdReady, fifoRdData,
    output wrReady, rdValid, rdData, fifoCount,
           fifoWrAddr, fifoWrite, fifoWrData, fifoRdAddr
  );

  modport slave (
    output wrValid, wrData, rdReady, fifoRdData,
    input  wrReady, rdValid, rdData, fifoCount,
           fifoWrAddr, fifoWrite, fifoWrData, fifoRdAddr
  );
endinterface

// File: rtl/caxi4interconnect_sync_fifo_ctrl.sv
// rtl/caxi4interconnect_sync_fifo_ctrl.sv - FWFT controller for a sync-write/sync-read dual-port RAM
//
// Purpose: manages write/read pointers into an external RAM with read latency
// L = 1 + HI_FREQ, prefetching RAM words through an L-stage valid pipe into a
// small output buffer so the pop side is first-word-fall-through at one word
// per cycle.
// Ports:
//   HCLK     - clock, rising edge
//   sysReset - synchronous active-high reset
//   bus      - master modport: push/pop handshakes, fifoCount, RAM port
module caxi4interconnect_sync_fifo_ctrl #(
  parameter int FIFO_AWIDTH = 9,
  parameter int FIFO_WIDTH  = 8,
  parameter int HI_FREQ     = 0
) (
  input  logic                               HCLK,
  input  logic                               sysReset,
  caxi4interconnect_sync_fifo_ctrl_if.master bus
);
  localparam int FIFO_DEPTH = 1 << FIFO_AWIDTH;
  localparam int L          = 1 + HI_FREQ;
  localparam int BUF_DEPTH  = L + 1;
  localparam int CW         = $clog2(BUF_DEPTH + 1);

  localparam logic [FIFO_AWIDTH-1:0] PTR_ONE = 1;
  localparam logic [FIFO_AWIDTH:0]   CNT_ONE = 1;

  logic [FIFO_AWIDTH-1:0]          wr_ptr;
  logic [FIFO_AWIDTH-1:0]          rd_ptr;
  logic [FIFO_AWIDTH:0]            ram_count;
  logic [FIFO_AWIDTH:0]            fifo_count;
  logic [L-1:0]                    pipe_q;
  logic [L:0]                      pipe_shift;
  logic [CW-1:0]                   in_flight;
  logic [CW-1:0]                   buf_count;
  logic [CW-1:0]                   buf_wr_idx;
  logic [CW:0]                     credit_used;
  logic [BUF_DEPTH*FIFO_WIDTH-1:0] buf_q;
  logic                            wr_ready;
  logic                            push;
  logic                            pop;
  logic                            rd_valid;
  logic                            rd_issue;
  logic                            pipe_exit;

  // wrReady depends only on the registered count and reset, so a pop at full
  // does not let a push through in the same cycle.
  assign wr_ready  = !sysReset && (fifo_count < (FIFO_AWIDTH+1)'(FIFO_DEPTH));
  assign push      = bus.wrValid && wr_ready;
  assign rd_valid  = (buf_count != '0);
  assign pop       = rd_valid && bus.rdReady;

  assign in_flight = CW'($countones(pipe_q));
  assign pipe_exit = pipe_q[L-1];

  // Every issued read owns a buffer slot until popped. A pop this cycle frees
  // a slot, which is what lets the steady state issue one read per cycle.
  assign credit_used = {1'b0, in_flight} + {1'b0, buf_count} - {{CW{1'b0}}, pop};
  assign rd_issue    = (ram_count != '0) && (credit_used < (CW+1)'(BUF_DEPTH));

  assign pipe_shift  = {pipe_q, rd_issue};

  // Landing slot for the RAM word leaving the pipe: just past the last valid
  // entry, after any pop has shifted the buffer down by one.
  assign buf_wr_idx  = buf_count - {{(CW-1){1'b0}}, pop};

  always_ff @(posedge HCLK) begin
    if (sysReset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_count  <= '0;
      fifo_count <= '0;
      pipe_q     <= '0;
      buf_count  <= '0;
      buf_q      <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_issue) rd_ptr <= rd_ptr + PTR_ONE;

      case ({push, rd_issue})
        2'b10:   ram_count <= ram_count + CNT_ONE;
        2'b01:   ram_count <= ram_count - CNT_ONE;
        default: ram_count <= ram_count;
      endcase

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase

      pipe_q    <= pipe_shift[L-1:0];
      buf_count <= buf_count + CW'(pipe_exit) - CW'(pop);

      // Head lives in slot 0; popping shifts the buffer down one word.
      if (pop) buf_q <= {{FIFO_WIDTH{1'b0}}, buf_q[BUF_DEPTH*FIFO_WIDTH-1:FIFO_WIDTH]};
      if (pipe_exit) buf_q[buf_wr_idx*FIFO_WIDTH +: FIFO_WIDTH] <= bus.fifoRdData;
    end
  end

  assign bus.wrReady    = wr_ready;
  assign bus.rdValid    = rd_valid;
  assign bus.rdData     = buf_q[FIFO_WIDTH-1:0];
  assign bus.fifoCount  = fifo_count;
  assign bus.fifoWrAddr = wr_ptr;
  assign bus.fifoWrite  = push;
  assign bus.fifoWrData = bus.wrData;
  assign bus.fifoRdAddr = rd_ptr;
endmodule
